// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_pkg
//  Description : Shared types and constants for the fetch-side branch target
//                buffer: 30-bit word-address type, BTB entry layout and the
//                counter values used on reset and on allocation.
//  Revision    : 1.0  initial release
// ============================================================================
package branch_predictor_pkg;

    localparam int PC_W = 30;

    typedef logic [PC_W-1:0] word_t;

    // The tag field holds the full branch word address. The low IDX_W bits
    // always equal the entry's own index, so a full-width compare is the
    // same as comparing only the upper tag bits; synthesis trims the rest.
    typedef struct packed {
        logic       valid;
        word_t      tag;
        word_t      target;
        logic [1:0] ctr;
    } bp_entry_t;

    // Weakly taken: a freshly allocated branch predicts taken at once.
    localparam logic [1:0] BP_CTR_INIT  = 2'b10;
    // Weakly not-taken: value held by every counter after reset.
    localparam logic [1:0] BP_CTR_RESET = 2'b01;

    localparam bp_entry_t BP_ENTRY_RESET = '{
        valid  : 1'b0,
        tag    : '0,
        target : '0,
        ctr    : BP_CTR_RESET
    };

endpackage : branch_predictor_pkg
`default_nettype wire

// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_if
//  Description : Signal bundle between the pipeline and the branch predictor.
//                Fetch side : f_pc -> bpSel, bp_a
//                EX side    : ex_en, ex_br, ex_pc, ex_npc, ex_taken,
//                             ex_target, ex_pred, ex_pred_a -> pdStatus, rpc
//                Statistics : br_cnt, mp_cnt
//                The predictor uses the slave modport, the pipeline the
//                master modport.
//  Revision    : 1.0  initial release
// ============================================================================
interface branch_predictor_if;
    import branch_predictor_pkg::*;

    // fetch lookup
    word_t       f_pc;
    logic        bpSel;
    word_t       bp_a;

    // EX resolve
    logic        ex_en;
    logic        ex_br;
    word_t       ex_pc;
    word_t       ex_npc;
    logic        ex_taken;
    word_t       ex_target;
    logic        ex_pred;
    word_t       ex_pred_a;
    logic        pdStatus;
    word_t       rpc;

    // event counters
    logic [31:0] br_cnt;
    logic [31:0] mp_cnt;

    modport master (
        output f_pc,
        input  bpSel, bp_a,
        output ex_en, ex_br, ex_pc, ex_npc, ex_taken, ex_target, ex_pred, ex_pred_a,
        input  pdStatus, rpc,
        input  br_cnt, mp_cnt
    );

    modport slave (
        input  f_pc,
        output bpSel, bp_a,
        input  ex_en, ex_br, ex_pc, ex_npc, ex_taken, ex_target, ex_pred, ex_pred_a,
        output pdStatus, rpc,
        output br_cnt, mp_cnt
    );

endinterface : branch_predictor_if
`default_nettype wire

// File: rtl/branch_predictor_sat_counter2.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_sat_counter2
//  Description : Next-state function of a 2-bit saturating up/down counter.
//                ctr      in  2  current value
//                up       in  1  1 = count toward 11, 0 = count toward 00
//                ctr_next out 2  saturated next value
//  Revision    : 1.0  initial release
// ============================================================================
module branch_predictor_sat_counter2 (
    input  wire logic [1:0] ctr,
    input  wire logic       up,
    output      logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (up) begin
            if (ctr != 2'b11) begin
                ctr_next = ctr + 2'd1;
            end
        end else begin
            if (ctr != 2'b00) begin
                ctr_next = ctr - 2'd1;
            end
        end
    end

endmodule : branch_predictor_sat_counter2
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Direct-mapped branch target buffer with 2-bit saturating
//                direction counters. Lookup on the fetch PC is zero-latency;
//                branch resolution from EX produces a mispredict flag and the
//                recovery PC, updates or allocates the entry and counts
//                resolved branches and mispredicts.
//                clk  in  1   clock
//                rst  in  1   synchronous active-high reset
//                bp   slave   see branch_predictor_if
//  Revision    : 1.0  initial release
// ============================================================================
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int         IDX_W    = 4,
    parameter logic [1:0] CTR_INIT = BP_CTR_INIT
) (
    input wire logic             clk,
    input wire logic             rst,
    branch_predictor_if.slave    bp
);

    localparam int ENTRIES = 2 ** IDX_W;

    bp_entry_t          r_btb [ENTRIES];
    logic [31:0]        r_br_cnt;
    logic [31:0]        r_mp_cnt;

    // ------------------------------------------------------------------
    // Fetch lookup (read port). Reads the registered table directly, so a
    // same-cycle update to the same index is not visible until next cycle.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]   w_f_idx;
    bp_entry_t          w_f_entry;
    logic               w_f_hit;
    logic               w_f_taken;

    always_comb begin
        w_f_idx   = bp.f_pc[IDX_W-1:0];
        w_f_entry = r_btb[w_f_idx];
        w_f_hit   = w_f_entry.valid && (w_f_entry.tag == bp.f_pc);
        w_f_taken = w_f_hit && w_f_entry.ctr[1];
    end

    assign bp.bpSel = w_f_taken;
    assign bp.bp_a  = w_f_taken ? w_f_entry.target : '0;

    // ------------------------------------------------------------------
    // EX resolve
    // ------------------------------------------------------------------
    logic               w_active;
    logic               w_mispredict;
    logic [IDX_W-1:0]   w_ex_idx;
    bp_entry_t          w_ex_entry;
    logic               w_ex_hit;
    logic [1:0]         w_ctr_next;

    always_comb begin
        w_active   = bp.ex_en && bp.ex_br;
        // A taken branch with the right direction but a stale target still
        // fetched the wrong path.
        w_mispredict = w_active &&
                       ((bp.ex_pred != bp.ex_taken) ||
                        (bp.ex_taken && (bp.ex_pred_a != bp.ex_target)));
        w_ex_idx   = bp.ex_pc[IDX_W-1:0];
        w_ex_entry = r_btb[w_ex_idx];
        w_ex_hit   = w_ex_entry.valid && (w_ex_entry.tag == bp.ex_pc);
    end

    assign bp.pdStatus = w_mispredict;
    // Recovery address is presented for any valid branch, even on a stall.
    assign bp.rpc      = bp.ex_br ? (bp.ex_taken ? bp.ex_target : bp.ex_npc) : '0;

    branch_predictor_sat_counter2 u_ctr (
        .ctr      (w_ex_entry.ctr),
        .up       (bp.ex_taken),
        .ctr_next (w_ctr_next)
    );

    // ------------------------------------------------------------------
    // Table write port and event counters. Reset has priority over any
    // update presented in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_btb[i] <= BP_ENTRY_RESET;
            end
            r_br_cnt <= '0;
            r_mp_cnt <= '0;
        end else if (w_active) begin
            r_br_cnt <= r_br_cnt + 32'd1;
            if (w_mispredict) begin
                r_mp_cnt <= r_mp_cnt + 32'd1;
            end
            if (w_ex_hit) begin
                r_btb[w_ex_idx].ctr <= w_ctr_next;
                if (bp.ex_taken) begin
                    r_btb[w_ex_idx].target <= bp.ex_target;
                end
            end else if (bp.ex_taken) begin
                // Miss on a taken branch: allocate, evicting any alias.
                r_btb[w_ex_idx] <= '{
                    valid  : 1'b1,
                    tag    : bp.ex_pc,
                    target : bp.ex_target,
                    ctr    : CTR_INIT
                };
            end
        end
    end

    assign bp.br_cnt = r_br_cnt;
    assign bp.mp_cnt = r_mp_cnt;

endmodule : branch_predictor
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor
//  Description : Scoreboard bench for branch_predictor. The driver applies
//                one vector per cycle and queues the values expected in that
//                cycle; a monitor on the falling edge pops and compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    localparam int S_BPSEL = 0;
    localparam int S_BPA   = 1;
    localparam int S_PD    = 2;
    localparam int S_RPC   = 3;
    localparam int S_BRC   = 4;
    localparam int S_MPC   = 5;

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cycle;
    int   checks;
    int   errors;
    exp_t q [$];

    branch_predictor_if bif ();

    branch_predictor #(.IDX_W(4), .CTR_INIT(2'b10)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [31:0] actual(int s);
        case (s)
            S_BPSEL: actual = {31'b0, bif.bpSel};
            S_BPA:   actual = {2'b0, bif.bp_a};
            S_PD:    actual = {31'b0, bif.pdStatus};
            S_RPC:   actual = {2'b0, bif.rpc};
            S_BRC:   actual = bif.br_cnt;
            default: actual = bif.mp_cnt;
        endcase
    endfunction

    // Monitor: every expectation queued for the current cycle is compared
    // while outputs are stable (falling edge).
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] a;
        while (q.size() > 0 && q[0].cyc <= cycle) begin
            e = q.pop_front();
            a = actual(e.sig);
            checks++;
            if (e.cyc != cycle || a !== e.val) begin
                errors++;
                $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", e.name, e.cyc, a, e.val);
            end
        end
    end

    task automatic expv(string n, int s, logic [31:0] v);
        q.push_back('{n, s, v, cycle});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(word_t fpc);
        bif.f_pc      = fpc;
        bif.ex_en     = 1'b0;
        bif.ex_br     = 1'b0;
        bif.ex_pc     = '0;
        bif.ex_npc    = '0;
        bif.ex_taken  = 1'b0;
        bif.ex_target = '0;
        bif.ex_pred   = 1'b0;
        bif.ex_pred_a = '0;
    endtask

    task automatic resolve(logic en, word_t pc, logic tk, word_t tgt, logic pr, word_t pra, word_t fpc);
        bif.f_pc      = fpc;
        bif.ex_en     = en;
        bif.ex_br     = 1'b1;
        bif.ex_pc     = pc;
        bif.ex_npc    = pc + 30'd1;
        bif.ex_taken  = tk;
        bif.ex_target = tgt;
        bif.ex_pred   = pr;
        bif.ex_pred_a = pra;
    endtask

    task automatic look(string n, logic sel, logic [31:0] a);
        expv({n, ".bpSel"}, S_BPSEL, {31'b0, sel});
        expv({n, ".bp_a"},  S_BPA,   a);
    endtask

    task automatic counts(string n, logic [31:0] br, logic [31:0] mp);
        expv({n, ".br_cnt"}, S_BRC, br);
        expv({n, ".mp_cnt"}, S_MPC, mp);
    endtask

    task automatic res(string n, logic pd, logic [31:0] r);
        expv({n, ".pdStatus"}, S_PD,  {31'b0, pd});
        expv({n, ".rpc"},      S_RPC, r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        idle(30'h100);
        step(); step();
        rst = 1'b0;

        // Reset state
        idle(30'h100);
        look("reset", 1'b0, 32'h0); res("reset", 1'b0, 32'h0); counts("reset", 0, 0);
        step();
        // Taken miss -> allocate; lookup same cycle still misses
        resolve(1'b1, 30'h100, 1'b1, 30'h200, 1'b0, 30'h0, 30'h100);
        res("alloc", 1'b1, 32'h200); look("alloc_same", 1'b0, 32'h0); counts("alloc", 0, 0);
        step();
        idle(30'h100);
        look("alloc_hit", 1'b1, 32'h200); counts("alloc", 1, 1);
        step();
        // Not taken, predicted taken: 10 -> 01
        resolve(1'b1, 30'h100, 1'b0, 30'h200, 1'b1, 30'h200, 30'h100);
        res("nt1", 1'b1, 32'h101); look("nt1_old", 1'b1, 32'h200);
        step();
        idle(30'h100);
        look("nt1_after", 1'b0, 32'h0); counts("nt1", 2, 2);
        step();
        // Not taken, predicted not taken: 01 -> 00
        resolve(1'b1, 30'h100, 1'b0, 30'h200, 1'b0, 30'h0, 30'h100);
        res("nt2", 1'b0, 32'h101);
        step();
        idle(30'h100);
        look("nt2_after", 1'b0, 32'h0); counts("nt2", 3, 2);
        step();
        // Taken twice from 00: 00 -> 01 -> 10, second with a new target
        resolve(1'b1, 30'h100, 1'b1, 30'h200, 1'b0, 30'h0, 30'h100);
        res("t1", 1'b1, 32'h200);
        step();
        idle(30'h100);
        look("t1_after", 1'b0, 32'h0); counts("t1", 4, 3);
        step();
        resolve(1'b1, 30'h100, 1'b1, 30'h240, 1'b0, 30'h0, 30'h100);
        res("t2", 1'b1, 32'h240);
        step();
        idle(30'h100);
        look("t2_after", 1'b1, 32'h240); counts("t2", 5, 4);
        step();
        // Alias 0x110 evicts 0x100; same-index lookup sees old entry
        resolve(1'b1, 30'h110, 1'b1, 30'h300, 1'b0, 30'h0, 30'h100);
        res("alias", 1'b1, 32'h300); look("alias_same", 1'b1, 32'h240);
        step();
        idle(30'h100);
        look("alias_old", 1'b0, 32'h0); counts("alias", 6, 5);
        step();
        idle(30'h110);
        look("alias_new", 1'b1, 32'h300);
        step();
        // Stall with a wrong prediction: no flush, no update, no count
        resolve(1'b0, 30'h110, 1'b0, 30'h300, 1'b1, 30'h300, 30'h110);
        res("stall", 1'b0, 32'h111);
        step();
        idle(30'h110);
        look("stall_after", 1'b1, 32'h300); counts("stall", 6, 5);
        step();
        // Correct taken prediction: 10 -> 11
        resolve(1'b1, 30'h110, 1'b1, 30'h300, 1'b1, 30'h300, 30'h110);
        res("good", 1'b0, 32'h300);
        step();
        idle(30'h110);
        counts("good", 7, 5);
        step();
        // Right direction, wrong target: mispredict; 11 saturates
        resolve(1'b1, 30'h110, 1'b1, 30'h310, 1'b1, 30'h300, 30'h110);
        res("tgt", 1'b1, 32'h310);
        step();
        idle(30'h110);
        look("tgt_after", 1'b1, 32'h310); counts("tgt", 8, 6);
        step();
        // Not taken from 11 -> 10 (still predicts taken)
        resolve(1'b1, 30'h110, 1'b0, 30'h310, 1'b1, 30'h310, 30'h110);
        res("sat", 1'b1, 32'h111);
        step();
        idle(30'h110);
        look("sat_after", 1'b1, 32'h310); counts("sat", 9, 7);
        step();
        // Not-taken miss: no allocation
        resolve(1'b1, 30'h123, 1'b0, 30'h400, 1'b0, 30'h0, 30'h123);
        res("ntmiss", 1'b0, 32'h124);
        step();
        idle(30'h123);
        look("ntmiss_after", 1'b0, 32'h0); counts("ntmiss", 10, 7);
        step();
        // Reset with an active update: reset wins
        rst = 1'b1;
        resolve(1'b1, 30'h123, 1'b1, 30'h400, 1'b0, 30'h0, 30'h123);
        step();
        rst = 1'b0;
        idle(30'h123);
        look("rst_upd", 1'b0, 32'h0); counts("rst", 0, 0);
        step();
        idle(30'h110);
        look("rst_inval", 1'b0, 32'h0);
        step();
        step();

        if (q.size() != 0) begin
            errors += q.size();
            checks += q.size();
            $display("FAIL scoreboard: %0d expectations never compared", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_branch_predictor
`default_nettype wire
